// File: rtl/binary16_mul.sv
// Iterative binary16 multiplier: 11-step shift-add, normalize, range check.
// Define BINARY16_MUL_ROUND_EN for round-to-nearest-even (default: truncate).
module binary16_mul #(
  parameter int MANT_W = 11
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        data_valid_in,
  output logic [15:0] result,
  output logic        data_valid_out,
  output logic        busy
);

  localparam int PW = 2 * MANT_W;

  typedef enum logic [1:0] {IDLE, MULT, NORM} state_t;
  typedef enum logic [1:0] {C_NUM, C_NAN, C_INF, C_ZERO} cls_t;

  state_t state_q, state_d;
  cls_t   cls_q, cls_d, in_cls;

  logic              sign_q, sign_d;
  logic [4:0]        ea_q, ea_d, eb_q, eb_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       res_q, res_d;
  logic              dvo_q, dvo_d;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [6:0]  e_raw, e_norm, e_fin;
  logic [9:0]  mant_t;
  logic [10:0] mant_r;
  logic [15:0] num;

  always_comb begin
    a_nan  = (&a[14:10]) & (|a[9:0]);
    b_nan  = (&b[14:10]) & (|b[9:0]);
    a_inf  = (&a[14:10]) & ~(|a[9:0]);
    b_inf  = (&b[14:10]) & ~(|b[9:0]);
    a_zero = ~(|a[14:10]);
    b_zero = ~(|b[14:10]);
    if (a_nan | b_nan)
      in_cls = C_NAN;
    else if ((a_inf & b_zero) | (b_inf & a_zero))
      in_cls = C_NAN;
    else if (a_inf | b_inf)
      in_cls = C_INF;
    else if (a_zero | b_zero)
      in_cls = C_ZERO;
    else
      in_cls = C_NUM;
  end

  // Product lies in [2^20, 2^22): top bit selects the normalization shift.
  always_comb begin
    e_raw = {2'b00, ea_q} + {2'b00, eb_q} - 7'd15;
    if (prod_q[PW-1]) begin
      mant_t = prod_q[20:11];
      e_norm = e_raw + 7'd1;
    end else begin
      mant_t = prod_q[19:10];
      e_norm = e_raw;
    end
`ifdef BINARY16_MUL_ROUND_EN
    begin
      logic g, st;
      g  = prod_q[PW-1] ? prod_q[10] : prod_q[9];
      st = prod_q[PW-1] ? (|prod_q[9:0]) : (|prod_q[8:0]);
      mant_r = {1'b0, mant_t} + 11'(g & (st | mant_t[0]));
    end
`else
    mant_r = {1'b0, mant_t};
`endif
    e_fin = e_norm + 7'(mant_r[10]);
    unique case (cls_q)
      C_NAN:  num = 16'h7E00;
      C_INF:  num = {sign_q, 5'h1F, 10'h000};
      C_ZERO: num = {sign_q, 15'h0000};
      default: begin
        if ($signed(e_fin) >= 7'sd31)
          num = {sign_q, 5'h1F, 10'h000};
        else if ($signed(e_fin) <= 7'sd0)
          num = {sign_q, 15'h0000};
        else
          num = {sign_q, e_fin[4:0], mant_r[9:0]};
      end
    endcase
  end

`ifndef BINARY16_MUL_ROUND_EN
  logic unused_lo;
  assign unused_lo = ^prod_q[9:0];
`endif

  always_ff @(posedge clk_in) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (data_valid_in) state_d = MULT;
      MULT:    if (cnt_q == 4'd1) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    cls_d    = cls_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    dvo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_valid_in) begin
          sign_d   = a[15] ^ b[15];
          ea_d     = a[14:10];
          eb_d     = b[14:10];
          cls_d    = in_cls;
          mcand_d  = {{(PW-MANT_W){1'b0}}, 1'b1, a[9:0]};
          mplier_d = {1'b1, b[9:0]};
          prod_d   = '0;
          cnt_d    = 4'd11;
        end
      end
      MULT: begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 4'd1;
      end
      NORM: begin
        res_d = num;
        dvo_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      cls_q    <= C_NUM;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      dvo_q    <= 1'b0;
    end else begin
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      cls_q    <= cls_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      dvo_q    <= dvo_d;
    end
  end

  assign result         = res_q;
  assign data_valid_out = dvo_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_binary16_mul.sv
// Bench for binary16_mul: behavioural model plus per-cycle compare,
// directed vectors with hand-computed results.
module tb_binary16_mul;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        data_valid_in = 1'b0;
  logic [15:0] result;
  logic        data_valid_out;
  logic        busy;

  int nvec = 0;
  int nmis = 0;
  bit started = 0;

  binary16_mul dut (
    .clk_in(clk_in),
    .rst(rst),
    .a(a),
    .b(b),
    .data_valid_in(data_valid_in),
    .result(result),
    .data_valid_out(data_valid_out),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] model(logic [15:0] x, logic [15:0] y);
    int ex, ey, e, p, sh, kept;
    logic s;
    bit xn, yn, xi, yi, xz, yz;
    s  = x[15] ^ y[15];
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    xn = (ex == 31) && (x[9:0] != 0);
    yn = (ey == 31) && (y[9:0] != 0);
    xi = (ex == 31) && (x[9:0] == 0);
    yi = (ey == 31) && (y[9:0] == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xn || yn) return 16'h7E00;
    if ((xi && yz) || (yi && xz)) return 16'h7E00;
    if (xi || yi) return {s, 5'h1F, 10'h000};
    if (xz || yz) return {s, 15'h0000};
    p = (1024 + int'(x[9:0])) * (1024 + int'(y[9:0]));
    e = ex + ey - 15;
    sh = 10;
    if (p >= (1 << 21)) begin
      sh = 11;
      e++;
    end
    kept = p >> sh;
`ifdef BINARY16_MUL_ROUND_EN
    begin
      int rem, half;
      rem  = p - (kept << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (kept % 2) == 1)) kept++;
      if (kept == 2048) begin
        kept = 1024;
        e++;
      end
    end
`endif
    if (e >= 31) return {s, 5'h1F, 10'h000};
    if (e <= 0) return {s, 15'h0000};
    return {s, 5'(e), 10'(kept - 1024)};
  endfunction

  // Cycle-level reference: one request in flight, 12 edges to completion.
  int          m_left = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_res = '0;
  logic        m_dvo = 1'b0;

  always @(posedge clk_in) begin
    if (rst) begin
      m_left = 0;
      m_res  = '0;
      m_dvo  = 1'b0;
    end else begin
      m_dvo = 1'b0;
      if (m_left == 1) begin
        m_res  = m_pend;
        m_dvo  = 1'b1;
        m_left = 0;
      end else if (m_left > 1) begin
        m_left--;
      end else if (data_valid_in) begin
        m_pend = model(a, b);
        m_left = 12;
      end
    end
  end

  always @(negedge clk_in) begin
    if (started) begin
      chk("cyc_dvo", {15'b0, data_valid_out}, {15'b0, m_dvo});
      chk("cyc_busy", {15'b0, busy}, {15'b0, (m_left != 0)});
      chk("cyc_result", result, m_res);
    end
  end

  // Issue one request at a negedge and wait for its completion pulse.
  task automatic run(logic [15:0] x, logic [15:0] y, logic [15:0] exp);
    int k, nb;
    bit seen;
    a = x;
    b = y;
    data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    nb = busy ? 1 : 0;
    seen = 0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk_in);
      k++;
      if (data_valid_out) seen = 1;
      else if (busy) nb++;
    end
    if (!seen) begin
      nmis++;
      nvec++;
      $display("FAIL timeout %h*%h: no data_valid_out in 40 cycles", x, y);
    end else begin
      chk($sformatf("res_%h_%h", x, y), result, exp);
      chk("latency", 16'(k), 16'd12);
      chk("busy_cycles", 16'(nb), 16'd12);
    end
  endtask

  logic [15:0] xa [6] = '{16'h3555, 16'hB8CD, 16'h5A3F, 16'h2001, 16'h47FF, 16'h0C01};
  logic [15:0] xb [6] = '{16'h3555, 16'h4D12, 16'h5801, 16'h1FFF, 16'h47FF, 16'h3BFF};

  initial begin
    int pulses;
    logic [15:0] e3e01;
    logic [15:0] rs;
`ifdef BINARY16_MUL_ROUND_EN
    e3e01 = 16'h4082;
`else
    e3e01 = 16'h4081;
`endif
    @(posedge clk_in);
    started = 1;
    @(negedge clk_in);
    chk("rst_result", result, 16'h0000);
    chk("rst_dvo", {15'b0, data_valid_out}, 16'h0);
    chk("rst_busy", {15'b0, busy}, 16'h0);
    rst = 1'b0;
    @(negedge clk_in);

    chk("model_2x-3", model(16'h4000, 16'hC200), 16'hC600);
    chk("model_3e01", model(16'h3E01, 16'h3E01), e3e01);

    run(16'h3C00, 16'h3C00, 16'h3C00);
    run(16'h4000, 16'hC200, 16'hC600);
    run(16'h3E00, 16'h3E00, 16'h4080);
    run(16'h7BFF, 16'h7BFF, 16'h7C00);
    run(16'h0400, 16'h3800, 16'h0000);
    run(16'h8000, 16'h3C00, 16'h8000);
    run(16'h7C00, 16'h0000, 16'h7E00);
    run(16'h7C00, 16'hC000, 16'hFC00);
    run(16'h7E01, 16'h3C00, 16'h7E00);
    run(16'h3E01, 16'h3E01, e3e01);
    for (int i = 0; i < 6; i++) run(xa[i], xb[i], model(xa[i], xb[i]));
    @(negedge clk_in);

    // Request while busy is dropped.
    a = 16'h4000;
    b = 16'h4000;
    data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    a = 16'h3C00;
    b = 16'h3C00;
    data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    pulses = 0;
    rs = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (data_valid_out) begin
        pulses++;
        rs = result;
      end
    end
    chk("busy_drop_pulses", 16'(pulses), 16'd1);
    chk("busy_drop_result", rs, 16'h4400);

    // Reset mid-operation aborts.
    a = 16'h4000;
    b = 16'h4000;
    data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    chk("abort_busy", {15'b0, busy}, 16'h0);
    chk("abort_result", result, 16'h0000);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (data_valid_out) pulses++;
    end
    chk("abort_pulses", 16'(pulses), 16'd0);
    run(16'h4200, 16'h4000, 16'h4600);
    repeat (2) @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
